// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux.
// Contended grant tenure is bounded by a hold counter; the muxed data is registered.
//
// state   | meaning
// IDLE    | no source granted; sel keeps its last value, y_valid drops next edge
// GRANT_A | source A owns the output (sel=0)
// GRANT_B | source B owns the output (sel=1)
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam int             CW        = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  state_t          state, state_nxt;
  logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
  logic            last_b, last_b_nxt;
  logic            sel_nxt;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_b_nxt   = last_b;
    sel_nxt      = sel;
    case (state)
      IDLE: begin
        if (req_a && req_b)  state_nxt = last_b ? GRANT_A : GRANT_B;
        else if (req_a)      state_nxt = GRANT_A;
        else if (req_b)      state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a)          state_nxt = req_b ? GRANT_B : IDLE;
        else if (req_b) begin
          if (hold_cnt == HOLD_LAST) state_nxt = GRANT_B;
          else                       hold_cnt_nxt = hold_cnt + CNT_ONE;
        end
      end
      GRANT_B: begin
        if (!req_b)          state_nxt = req_a ? GRANT_A : IDLE;
        else if (req_a) begin
          if (hold_cnt == HOLD_LAST) state_nxt = GRANT_A;
          else                       hold_cnt_nxt = hold_cnt + CNT_ONE;
        end
      end
      default:               state_nxt = IDLE;
    endcase

    // Tenure count restarts on every ownership change, including release to IDLE.
    if (state_nxt != state) hold_cnt_nxt = '0;

    if (state_nxt == GRANT_A) begin
      last_b_nxt = 1'b0;
      sel_nxt    = 1'b0;
    end else if (state_nxt == GRANT_B) begin
      last_b_nxt = 1'b1;
      sel_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_b   <= 1'b1;
      sel      <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_b   <= last_b_nxt;
      sel      <= sel_nxt;
      // Output stage follows the grant by one edge; y is frozen while idle.
      if (state != IDLE) begin
        y       <= sel ? data_b : data_a;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

  assign gnt_a = (state == GRANT_A);
  assign gnt_b = (state == GRANT_B);

endmodule
